bs_sequencer: RTL and testbench

//  Program sequencer for the bit-serial datapath. Drives the 3-bit PC into the

---
 rtl/bs_sequencer.sv | 92 +++++++++
 tb/tb_bs_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_sequencer.sv
// bs_sequencer: program sequencer issuing per-bit enables for a bit-serial datapath
module bs_sequencer #(
  parameter int DATA_W    = 8,
  parameter int STALL_CYC = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_sw,
  output logic [2:0]                o_pc,
  input  logic [2:0]                i_instr,
  output logic [2:0]                o_op,
  output logic                      o_bit_en,
  output logic [$clog2(DATA_W)-1:0] o_bit_idx,
  output logic                      o_first_bit,
  output logic                      o_last_bit,
  output logic                      o_busy,
  output logic                      o_done
);
  localparam int BW = $clog2(DATA_W);
  localparam int SW = $clog2(STALL_CYC + 1);
  localparam logic [2:0] OP_NOP = 3'b000, OP_STALL = 3'b001, OP_WAIT = 3'b110, OP_RSV = 3'b101;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_STALL, S_WAIT} state_t;
  state_t state, state_n;
  logic [2:0] pc, pc_n, op, op_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [SW-1:0] stall_cnt, stall_n;
  logic bit_last, stall_last;
  assign bit_last   = bit_idx == BW'(DATA_W - 1);
  assign stall_last = stall_cnt == SW'(STALL_CYC - 1);
  // state, pc, latched opcode and the two counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      op        <= '0;
      bit_idx   <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      op        <= op_n;
      bit_idx   <= bit_n;
      stall_cnt <= stall_n;
    end
  end
  // next state: dropping the run switch anywhere outside IDLE returns to IDLE at pc 0
  always_comb begin
    state_n = state;
    pc_n    = pc;
    op_n    = op;
    bit_n   = bit_idx;
    stall_n = stall_cnt;
    if (state != S_IDLE && !i_sw) begin
      state_n = S_IDLE;
      pc_n    = '0;
      bit_n   = '0;
      stall_n = '0;
    end else begin
      case (state)
        S_IDLE: state_n = i_sw ? S_FETCH : S_IDLE;
        S_FETCH: begin
          op_n = i_instr;
          case (i_instr)
            OP_STALL:       state_n = S_STALL;
            OP_WAIT:        state_n = S_WAIT;
            OP_NOP, OP_RSV: pc_n = pc + 3'd1;
            default:        state_n = S_EXEC;
          endcase
        end
        S_EXEC: begin
          bit_n   = bit_last ? '0 : bit_idx + BW'(1);
          pc_n    = bit_last ? pc + 3'd1 : pc;
          state_n = bit_last ? S_FETCH : S_EXEC;
        end
        S_STALL: begin
          stall_n = stall_last ? '0 : stall_cnt + SW'(1);
          pc_n    = stall_last ? pc + 3'd1 : pc;
          state_n = stall_last ? S_FETCH : S_STALL;
        end
        default: state_n = state;
      endcase
    end
  end
  assign o_pc        = pc;
  assign o_op        = op;
  assign o_bit_en    = state == S_EXEC;
  assign o_bit_idx   = bit_idx;
  assign o_first_bit = o_bit_en && bit_idx == '0;
  assign o_last_bit  = o_bit_en && bit_last;
  assign o_busy      = state inside {S_FETCH, S_EXEC, S_STALL};
  assign o_done      = state == S_WAIT;
endmodule

// File: tb/tb_bs_sequencer.sv
// tb_bs_sequencer: randomized trace comparison of bs_sequencer against a program-level model
module tb_bs_sequencer;
  localparam int DW = 8;
  localparam int SC = 2;
  typedef struct packed {
    logic [2:0] pc;
    logic [2:0] op;
    logic       en;
    logic [2:0] idx;
    logic       first;
    logic       last;
    logic       busy;
    logic       done;
  } rec_t;
  logic i_clk, i_rst, i_sw;
  logic [2:0] o_pc, i_instr, o_op, o_bit_idx;
  logic o_bit_en, o_first_bit, o_last_bit, o_busy, o_done;
  logic [2:0] imem [8];
  logic [13:0] obs;
  rec_t exp_q [$];
  logic [2:0] m_op;
  int total, bad;
  bs_sequencer #(.DATA_W(DW), .STALL_CYC(SC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sw(i_sw), .o_pc(o_pc), .i_instr(i_instr),
    .o_op(o_op), .o_bit_en(o_bit_en), .o_bit_idx(o_bit_idx), .o_first_bit(o_first_bit),
    .o_last_bit(o_last_bit), .o_busy(o_busy), .o_done(o_done)
  );
  assign i_instr = imem[o_pc];
  assign obs = {o_pc, o_op, o_bit_en, o_bit_idx, o_first_bit, o_last_bit, o_busy, o_done};
  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  function automatic rec_t mk(logic [2:0] pc, logic [2:0] op, logic en, int idx, logic busy, logic done);
    rec_t r;
    r.pc = pc; r.op = op; r.en = en; r.idx = 3'(idx);
    r.first = en && idx == 0;
    r.last = en && idx == DW - 1;
    r.busy = busy; r.done = done;
    return r;
  endfunction
  // expected per-cycle outputs from the first FETCH onward, walking the program op by op
  task automatic build(input int n, input logic [2:0] lop);
    logic [2:0] pc, ins;
    pc = 3'd0;
    exp_q.delete();
    while (exp_q.size() < n) begin
      ins = imem[pc];
      exp_q.push_back(mk(pc, lop, 0, 0, 1, 0));
      lop = ins;
      if (ins inside {3'b111, 3'b010, 3'b011, 3'b100}) begin
        for (int b = 0; b < DW; b++) exp_q.push_back(mk(pc, ins, 1, b, 1, 0));
        pc = pc + 3'd1;
      end else if (ins == 3'b001) begin
        for (int s = 0; s < SC; s++) exp_q.push_back(mk(pc, ins, 0, 0, 1, 0));
        pc = pc + 3'd1;
      end else if (ins == 3'b110) begin
        while (exp_q.size() < n) exp_q.push_back(mk(pc, ins, 0, 0, 0, 1));
      end else pc = pc + 3'd1;
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset();
    i_rst = 1; i_sw = 0;
    step(); step();
    i_rst = 0; m_op = 3'd0;
  endtask
  task automatic load_demo();
    imem[0] = 3'b000; imem[1] = 3'b111; imem[2] = 3'b001; imem[3] = 3'b010;
    imem[4] = 3'b001; imem[5] = 3'b011; imem[6] = 3'b100; imem[7] = 3'b110;
  endtask
  task automatic test_reset();
    i_rst = 1; i_sw = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== 14'd0) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=0", i, obs); end
      i_sw = 1'($urandom);
    end
    i_sw = 1;
    step();
    i_rst = 0;
    step();
    total++;
    if (obs !== mk(0, 0, 0, 0, 1, 0)) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, mk(0, 0, 0, 0, 1, 0)); end
    i_sw = 0;
    step();
    total++;
    if (obs !== 14'd0) begin bad++; $display("FAIL fetch_abort got=%h exp=0", obs); end
    m_op = 3'd0;
  endtask
  task automatic test_program();
    int ens, done_at;
    load_demo();
    do_reset();
    build(48, m_op);
    ens = 0; done_at = -1;
    i_sw = 1;
    for (int i = 0; i < 48; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL program cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
      if (o_bit_en) ens++;
      if (o_done && done_at < 0) done_at = i;
    end
    total++;
    if (ens != 32) begin bad++; $display("FAIL program_bit_en got=%0d exp=32", ens); end
    total++;
    if (done_at != 44) begin bad++; $display("FAIL program_done_at got=%0d exp=44", done_at); end
  endtask
  task automatic test_wait_exit();
    int done_at;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (obs !== mk(7, 3'b110, 0, 0, 0, 1)) begin bad++; $display("FAIL wait_hold cyc=%0d got=%h exp=%h", i, obs, mk(7, 3'b110, 0, 0, 0, 1)); end
    end
    i_sw = 0;
    step();
    total++;
    if (obs !== mk(0, 3'b110, 0, 0, 0, 0)) begin bad++; $display("FAIL wait_release got=%h exp=%h", obs, mk(0, 3'b110, 0, 0, 0, 0)); end
    m_op = 3'b110;
    build(46, m_op);
    done_at = -1;
    i_sw = 1;
    for (int i = 0; i < 46; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL rerun cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
      if (o_done && done_at < 0) done_at = i;
    end
    total++;
    if (done_at != 44) begin bad++; $display("FAIL rerun_done_at got=%0d exp=44", done_at); end
    i_sw = 0;
    step();
    m_op = 3'b110;
  endtask
  task automatic test_abort_exec();
    int lasts;
    load_demo();
    build(18, m_op);
    lasts = 0;
    i_sw = 1;
    for (int i = 0; i < 18; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL abort_run cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
      if (i >= 14 && o_last_bit) lasts++;
    end
    total++;
    if (o_bit_idx !== 3'd3 || o_op !== 3'b010) begin bad++; $display("FAIL abort_point got idx=%0d op=%0d exp idx=3 op=2", o_bit_idx, o_op); end
    i_sw = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs !== mk(0, 3'b010, 0, 0, 0, 0)) begin bad++; $display("FAIL abort_idle cyc=%0d got=%h exp=%h", i, obs, mk(0, 3'b010, 0, 0, 0, 0)); end
      if (o_last_bit) lasts++;
    end
    total++;
    if (lasts != 0) begin bad++; $display("FAIL abort_last_bit got=%0d exp=0", lasts); end
    m_op = 3'b010;
  endtask
  task automatic test_wrap();
    int ens;
    for (int i = 0; i < 8; i++) imem[i] = 3'b000;
    build(20, m_op);
    ens = 0;
    i_sw = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
      if (o_bit_en) ens++;
    end
    total++;
    if (ens != 0 || o_pc !== 3'd3) begin bad++; $display("FAIL wrap_end got en=%0d pc=%0d exp en=0 pc=3", ens, o_pc); end
    i_sw = 0;
    step();
    m_op = 3'b000;
  endtask
  task automatic test_reserved();
    for (int i = 0; i < 8; i++) imem[i] = 3'($urandom);
    imem[0] = 3'b000; imem[1] = 3'b000; imem[2] = 3'b101;
    build(14, m_op);
    i_sw = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL reserved cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
      if (i == 3) begin
        total++;
        if (o_pc !== 3'd3 || o_busy !== 1'b1) begin bad++; $display("FAIL reserved_pc got pc=%0d busy=%0d exp pc=3 busy=1", o_pc, o_busy); end
      end
    end
    i_sw = 0;
    step();
    m_op = exp_q[13].op;
  endtask
  task automatic test_reset_mid_stall();
    for (int i = 0; i < 8; i++) imem[i] = 3'($urandom);
    imem[0] = 3'b001;
    build(12, m_op);
    i_sw = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL stall_run cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
    end
    i_rst = 1;
    step();
    total++;
    if (obs !== 14'd0) begin bad++; $display("FAIL stall_reset got=%h exp=0", obs); end
    i_rst = 0;
    build(12, 3'b000);
    step();
    total++;
    if (obs !== exp_q[0]) begin bad++; $display("FAIL stall_refetch got=%h exp=%h", obs, exp_q[0]); end
    for (int i = 1; i < 12; i++) begin
      step();
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL stall_resume cyc=%0d got=%h exp=%h", i, obs, exp_q[i]); end
    end
    i_sw = 0;
    step();
    m_op = exp_q[11].op;
  endtask
  task automatic test_random();
    int k;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) imem[i] = 3'($urandom);
      k = $urandom_range(0, 80);
      build(k + 1, m_op);
      i_sw = 1;
      for (int i = 0; i <= k; i++) begin
        step();
        total++;
        if (obs !== exp_q[i]) begin bad++; $display("FAIL random r=%0d cyc=%0d got=%h exp=%h", r, i, obs, exp_q[i]); end
      end
      i_sw = 0;
      step();
      total++;
      if (obs !== mk(0, exp_q[k].op, 0, 0, 0, 0)) begin bad++; $display("FAIL random_abort r=%0d got=%h exp=%h", r, obs, mk(0, exp_q[k].op, 0, 0, 0, 0)); end
      m_op = exp_q[k].op;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    end
  endtask
  initial begin
    total = 0; bad = 0;
    i_rst = 1; i_sw = 0; m_op = 3'd0;
    for (int i = 0; i < 8; i++) imem[i] = 3'd0;
    test_reset();
    test_program();
    test_wait_exit();
    test_abort_exec();
    test_wrap();
    test_reserved();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
